// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream through a 3-entry skid buffer.
// Latency: r_en in cycle t -> m_valid in t+2; back-pressure stalls r_en once buffered + in-flight words reach 3.
module fifo_stream_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             r_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             idle,
    output logic [CNT_W-1:0] word_cnt
);

    logic [WIDTH-1:0] buf_q [3];
    logic [WIDTH-1:0] buf_d [3];
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [2:0]       credit_used;
    logic             push;
    logic             pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        // Every word either buffered or still coming back from the FIFO holds a slot.
        credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
        r_en        = rst_n && en && !empty && (credit_used < 3'd3);
        m_valid     = (occ_q != 2'd0);
        m_data      = buf_q[head_q];
        idle        = (occ_q == 2'd0) && !inflight_q;
        word_cnt    = word_cnt_q;
        push        = inflight_q;
        pop         = m_valid && m_ready;

        buf_d       = buf_q;
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        inflight_d  = r_en;
        word_cnt_d  = word_cnt_q;

        if (push) begin
            buf_d[tail_q] = data_out;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d     = ptr_inc(head_q);
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q      <= '{default: '0};
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            buf_q      <= buf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && (occ_q == 2'd3)));
        end
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's synchronous FIFO. It issues `r_en` against the FIFO's `empty` flag and captures `data_out` one cycle after each accepted read. It then presents the words downstream as a valid/ready stream, buffered so that full throughput holds under back-pressure. It sits between the FIFO read port and any streaming consumer, and is the counterpart of the write-side driver.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO.
- `CNT_W`, 16, width of the delivered-word counter.
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: reset, synchronous, active-low.
- `en` input 1: when high, the reader may issue new FIFO reads.
- `empty` input 1: FIFO empty flag.
- `data_out` input WIDTH: FIFO read data, valid in the cycle after an accepted `r_en`.
- `r_en` output 1: FIFO read enable.
- `m_valid` output 1: downstream word available.
- `m_data` output WIDTH: downstream word.
- `m_ready` input 1: downstream accepts the word when `m_valid && m_ready`.
- `idle` output 1: no buffered word and no read in flight.
- `word_cnt` output CNT_W: count of words delivered downstream; wraps.

## Operation
- **Internal state**
  - 3-entry output buffer (circular, 2-bit head/tail pointers, occupancy `occ` 0..3).
  - `inflight` flag: a read was issued last cycle.
- **Read issue**
  - `r_en = rst_n && en && !empty && (occ + inflight < 3)`.
  - `r_en` is combinational but has no dependence on `m_ready`.
  - `r_en` is never asserted while `empty` is high.
- **Capture**
  - `inflight` is registered from `r_en`.
  - When `inflight == 1`, `data_out` is written at the buffer tail at the posedge ending that cycle.
- **Pop**
  - `m_valid = (occ != 0)` and `m_data = buffer[head]`.
  - A pop occurs on `m_valid && m_ready`: head advances and `word_cnt` increments, wrapping 2^CNT_W-1 → 0.
- **Simultaneous capture and pop:** `occ` is unchanged and both pointers advance.
- **Ordering:** words are delivered in exact FIFO read order, with no drops or duplicates.
- **Deasserting `en`:** stops new reads only. An in-flight word is still captured and buffered words still drain.
- **Flow control:** `m_valid` must not drop and `m_data` must not change while `m_valid && !m_ready`.
- **`idle`:** equals `(occ == 0) && !inflight`.
- **Overflow:** impossible by construction. The credit rule bounds `occ + inflight ≤ 3`. Assert `occ ≤ 3` in simulation.

## Timing
- **Reset (`rst_n` low at a posedge):**
  - `occ`, pointers, `inflight` and `word_cnt` are set to 0; buffer contents are zeroed.
  - `m_valid` = 0, `m_data` = 0, `idle` = 1.
  - `r_en` is forced to 0 combinationally while `rst_n` is low.
- **Reset mid-operation:** buffered and in-flight words are discarded. The FIFO is reset in the same window.
- **Latency:** `r_en` high in cycle t → `data_out` valid in t+1 → `m_valid` high in t+2 (if the buffer was empty).
- **Throughput:** with `m_ready` held high and the FIFO non-empty, one word per cycle after the 2-cycle fill.
- **Back-pressure:** with `m_ready` low, at most 3 FIFO reads are issued before `r_en` stalls. Reads resume in the cycle after the first pop.
- **Empty:** when `empty` rises, `r_en` drops in the same cycle. A word in flight from the previous cycle is still captured.
- **Inputs:** `en`, `empty` and `m_ready` are sampled at posedge. Recommended bench drive is a few ns after posedge.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 cycles with `en`=1 and `empty`=0 → `r_en`=0, `m_valid`=0, `m_data`=0, `word_cnt`=0, `idle`=1.
- **Streaming:** FIFO preloaded with 8 words 0x10..0x17, `en`=1, `m_ready`=1 → `m_data` sequence 0x10..0x17 on 8 consecutive cycles starting 2 cycles after the first `r_en`; `word_cnt`=8; `idle`=1 at end.
- **Back-pressure:** FIFO holds 0xA0..0xA5, `m_ready`=0 → exactly 3 `r_en` pulses, `occ`=3, `m_data`=0xA0 held stable. Then `m_ready`=1 → 0xA0..0xA5 delivered in order, none lost.
- **Random stall:** `m_ready` toggled pseudo-randomly over 100 words while the writer fills concurrently → scoreboard shows in-order match, no `r_en` while `empty`, no `r_en` overflow.
- **`en` gating:** drop `en` the cycle after the first `r_en` → that word is still delivered, no further reads. Re-raise `en` → reading resumes.
- **Reset mid-burst and wrap:** assert `rst_n`=0 with `occ`=2 and `inflight`=1 → all state cleared next cycle and no stale word appears afterward. Separately, preload `word_cnt` near 0xFFFF and deliver 2 words → `word_cnt` wraps 0xFFFF → 0x0000 → 0x0001.
